// File: rtl/aq_vlsu_pkg.sv
// Shared VLSU definitions: sequencer FSM encodings, memory size codes and
// the forward-path datapath width in bytes.
package aq_vlsu_pkg;

  localparam int LSU_BYTEW = 8;  // bytes per 64-bit forward beat

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WARM  = 2'b01,
    ST_FWD   = 2'b10,
    ST_DRAIN = 2'b11
  } st_fwd_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_t;

endpackage

// File: rtl/aq_vlsu_st_beat_calc.sv
// Combinational beat arithmetic for one committed destination beat.
//   addr_q     in   current destination address [3:0]
//   dst_left   in   bytes still to commit
//   dst_next   out  dst_left after this beat
//   addr_next  out  addr_q after this beat (mod 16)
// A beat carries bytes up to the next 8-byte boundary, clipped to what is left.
module aq_vlsu_st_beat_calc
  import aq_vlsu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic [3:0]       addr_q,
  input  logic [LEN_W-1:0] dst_left,
  output logic [LEN_W-1:0] dst_next,
  output logic [3:0]       addr_next
);

  logic [3:0] room;
  logic [3:0] beat_bytes;

  // room is 1..8: bytes until the next doubleword boundary
  assign room       = 4'(LSU_BYTEW) - {1'b0, addr_q[2:0]};
  assign beat_bytes = (dst_left < {{(LEN_W-4){1'b0}}, room}) ? dst_left[3:0] : room;
  assign dst_next   = dst_left - {{(LEN_W-4){1'b0}}, beat_bytes};
  assign addr_next  = addr_q + beat_bytes;

endmodule

// File: rtl/aq_vlsu_st_fwd_ctrl.sv
// Vector store align-buffer sequencer. Accepts one unit-stride store, emits a
// warm-up pulse, then drives per-beat source-valid / seq-last / rotate controls
// while counting source beats consumed (fwd_next) and destination bytes
// committed (lsu_fwd_done). st_done pulses with the final committing beat.
//   align_clk, cpurst_b          clock, async active-low reset
//   rtu_yy_xx_flush              sync abort
//   req_*                        store request (rdy only in IDLE)
//   fwd_next, lsu_fwd_done       source consumed / destination beat accepted
//   vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up   align buffer controls
//   lsu_fwd_rot, lsu_fwd_inst_size, lsu_fwd_sew     LSU forward controls
//   st_done                      last byte committed
module aq_vlsu_st_fwd_ctrl
  import aq_vlsu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             align_clk,
  input  logic             cpurst_b,
  input  logic             rtu_yy_xx_flush,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [3:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [1:0]       req_inst_size,
  input  logic [1:0]       req_sew,
  input  logic             fwd_next,
  input  logic             lsu_fwd_done,
  output logic             vlsu_fwd_vld,
  output logic             vlsu_reg_seq_last,
  output logic             vlsu_warm_up,
  output logic [3:0]       lsu_fwd_rot,
  output logic [1:0]       lsu_fwd_inst_size,
  output logic [1:0]       lsu_fwd_sew,
  output logic             st_done
);

  localparam int SRC_W = LEN_W - 2;

  st_fwd_state_t    state;
  logic [3:0]       addr_q;
  logic [LEN_W-1:0] dst_left;
  logic [SRC_W-1:0] src_left;
  logic [1:0]       inst_size_q;
  logic [1:0]       sew_q;

  logic [LEN_W:0]   len_p7;
  logic [SRC_W-1:0] src_init;
  logic [SRC_W-1:0] src_nxt;
  logic [LEN_W-1:0] dst_next;
  logic [3:0]       addr_next;
  logic             busy;
  logic             src_dec;
  logic             dst_dec;
  logic             last_done;

  // ceil(len/8) with one guard bit so len near 2^LEN_W-1 cannot overflow
  assign len_p7   = {1'b0, req_len} + (LEN_W+1)'(7);
  assign src_init = len_p7[LEN_W:3];

  assign busy      = (state == ST_FWD) || (state == ST_DRAIN);
  assign src_dec   = busy && fwd_next && (src_left != '0);
  assign dst_dec   = busy && lsu_fwd_done;
  assign src_nxt   = src_left - {{(SRC_W-1){1'b0}}, src_dec};
  assign last_done = dst_dec && (dst_next == '0) && !rtu_yy_xx_flush;

  aq_vlsu_st_beat_calc #(.LEN_W(LEN_W)) u_beat_calc (
    .addr_q    (addr_q),
    .dst_left  (dst_left),
    .dst_next  (dst_next),
    .addr_next (addr_next)
  );

  always_ff @(posedge align_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      dst_left    <= '0;
      src_left    <= '0;
      inst_size_q <= '0;
      sew_q       <= '0;
    end else if (rtu_yy_xx_flush) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      dst_left    <= '0;
      src_left    <= '0;
      inst_size_q <= '0;
      sew_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_vld) begin
          addr_q      <= req_addr;
          dst_left    <= req_len;
          src_left    <= src_init;
          inst_size_q <= req_inst_size;
          sew_q       <= req_sew;
          state       <= ST_WARM;
        end
        ST_WARM: state <= ST_FWD;
        default: begin  // FWD / DRAIN: both counters move independently
          src_left <= src_nxt;
          if (dst_dec) begin
            dst_left <= dst_next;
            addr_q   <= addr_next;
          end
          // finishing the destination wins over entering DRAIN
          if (dst_dec && (dst_next == '0)) begin
            state    <= ST_IDLE;
            src_left <= '0;
          end else if ((state == ST_FWD) && (src_nxt == '0)) begin
            state <= ST_DRAIN;
          end
        end
      endcase
    end
  end

  assign req_rdy           = (state == ST_IDLE);
  assign vlsu_warm_up      = (state == ST_WARM);
  assign vlsu_fwd_vld      = busy && (src_left != '0);
  assign vlsu_reg_seq_last = busy && (src_left == SRC_W'(1));
  assign lsu_fwd_rot       = busy ? addr_q : 4'd0;
  assign lsu_fwd_inst_size = inst_size_q;
  assign lsu_fwd_sew       = sew_q;
  assign st_done           = last_done;

endmodule

// File: tb/tb_aq_vlsu_st_fwd_ctrl.sv
module tb_aq_vlsu_st_fwd_ctrl;

  localparam int LEN_W = 8;

  logic             align_clk;
  logic             cpurst_b;
  logic             rtu_yy_xx_flush;
  logic             req_vld;
  logic             req_rdy;
  logic [3:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic [1:0]       req_inst_size;
  logic [1:0]       req_sew;
  logic             fwd_next;
  logic             lsu_fwd_done;
  logic             vlsu_fwd_vld;
  logic             vlsu_reg_seq_last;
  logic             vlsu_warm_up;
  logic [3:0]       lsu_fwd_rot;
  logic [1:0]       lsu_fwd_inst_size;
  logic [1:0]       lsu_fwd_sew;
  logic             st_done;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [3:0] rot;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  aq_vlsu_st_fwd_ctrl #(.LEN_W(LEN_W)) dut (
    .align_clk         (align_clk),
    .cpurst_b          (cpurst_b),
    .rtu_yy_xx_flush   (rtu_yy_xx_flush),
    .req_vld           (req_vld),
    .req_rdy           (req_rdy),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .req_inst_size     (req_inst_size),
    .req_sew           (req_sew),
    .fwd_next          (fwd_next),
    .lsu_fwd_done      (lsu_fwd_done),
    .vlsu_fwd_vld      (vlsu_fwd_vld),
    .vlsu_reg_seq_last (vlsu_reg_seq_last),
    .vlsu_warm_up      (vlsu_warm_up),
    .lsu_fwd_rot       (lsu_fwd_rot),
    .lsu_fwd_inst_size (lsu_fwd_inst_size),
    .lsu_fwd_sew       (lsu_fwd_sew),
    .st_done           (st_done)
  );

  initial align_clk = 1'b0;
  always #5 align_clk = ~align_clk;

  // Scoreboard: every committed destination beat pops one expected
  // {rotate, is-last} entry; st_done must coincide with the last one.
  always @(negedge align_clk) begin
    if (mon_en && cpurst_b && lsu_fwd_done && !rtu_yy_xx_flush) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: unexpected done beat rot=%0h", lsu_fwd_rot);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (lsu_fwd_rot !== e.rot || st_done !== e.last) begin
          bad++;
          $display("FAIL sb_beat: rot=%0h st_done=%0b want rot=%0h st_done=%0b",
                   lsu_fwd_rot, st_done, e.rot, e.last);
        end
      end
    end
  end

  // Reference model of destination beat splitting, filled at request time.
  task automatic push_model(input int addr, input int len);
    int a, d, room, b;
    exp_t e;
    a = addr;
    d = len;
    while (d > 0) begin
      room = 8 - (a % 8);
      b = (d < room) ? d : room;
      d -= b;
      e.rot  = 4'(a);
      e.last = (d == 0);
      exp_q.push_back(e);
      a = (a + b) % 16;
    end
  endtask

  task automatic tick();
    @(posedge align_clk);
    #1;
  endtask

  task automatic drive(input bit nxt, input bit dn);
    fwd_next     = nxt;
    lsu_fwd_done = dn;
    tick();
    fwd_next     = 1'b0;
    lsu_fwd_done = 1'b0;
  endtask

  // Presents a request for one accepting edge; leaves the DUT in WARM.
  task automatic start_req(input int addr, input int len, input int sz, input int sew);
    req_addr      = 4'(addr);
    req_len       = LEN_W'(len);
    req_inst_size = 2'(sz);
    req_sew       = 2'(sew);
    req_vld       = 1'b1;
    push_model(addr, len);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
         lsu_fwd_inst_size, lsu_fwd_sew, st_done} !== {1'b1, 3'b000, 4'h0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b last=%0b warm=%0b rot=%0h sz=%0h sew=%0h done=%0b want rdy=1 rest 0",
               req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
               lsu_fwd_inst_size, lsu_fwd_sew, st_done);
    end
    @(negedge align_clk);
    cpurst_b = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    start_req(0, 16, 3, 2);
    total++;
    if (vlsu_warm_up !== 1'b1 || vlsu_fwd_vld !== 1'b0 || req_rdy !== 1'b0) begin
      bad++;
      $display("FAIL aligned_warm: warm=%0b vld=%0b rdy=%0b want 1 0 0", vlsu_warm_up, vlsu_fwd_vld, req_rdy);
    end
    tick();
    total++;
    if (vlsu_warm_up !== 1'b0 || vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b0 || lsu_fwd_rot !== 4'h0) begin
      bad++;
      $display("FAIL aligned_beat1: warm=%0b vld=%0b last=%0b rot=%0h want 0 1 0 0",
               vlsu_warm_up, vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'h8) begin
      bad++;
      $display("FAIL aligned_beat2: vld=%0b last=%0b rot=%0h want 1 1 8", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
    total++;
    if (req_rdy !== 1'b1 || vlsu_fwd_vld !== 1'b0 || lsu_fwd_inst_size !== 2'd3 || lsu_fwd_sew !== 2'd2) begin
      bad++;
      $display("FAIL aligned_end: rdy=%0b vld=%0b sz=%0h sew=%0h want 1 0 3 2",
               req_rdy, vlsu_fwd_vld, lsu_fwd_inst_size, lsu_fwd_sew);
    end
  endtask

  task automatic test_misaligned();
    start_req(5, 16, 1, 1);
    tick();
    drive(1, 0);
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'h5) begin
      bad++;
      $display("FAIL mis_beat2: vld=%0b last=%0b rot=%0h want 1 1 5", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 0);
    // DRAIN: sources exhausted, bytes still pending
    total++;
    if (vlsu_fwd_vld !== 1'b0 || vlsu_reg_seq_last !== 1'b0 || req_rdy !== 1'b0 || lsu_fwd_rot !== 4'h5) begin
      bad++;
      $display("FAIL mis_drain: vld=%0b last=%0b rdy=%0b rot=%0h want 0 0 0 5",
               vlsu_fwd_vld, vlsu_reg_seq_last, req_rdy, lsu_fwd_rot);
    end
    for (int i = 0; i < 3; i++) drive(0, 1);
    total++;
    if (req_rdy !== 1'b1 || lsu_fwd_inst_size !== 2'd1) begin
      bad++;
      $display("FAIL mis_end: rdy=%0b sz=%0h want 1 1", req_rdy, lsu_fwd_inst_size);
    end
  endtask

  task automatic test_short();
    start_req(14, 1, 0, 0);
    tick();
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'he) begin
      bad++;
      $display("FAIL short_beat: vld=%0b last=%0b rot=%0h want 1 1 e", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
    total++;
    if (req_rdy !== 1'b1 || lsu_fwd_inst_size !== 2'd0) begin
      bad++;
      $display("FAIL short_end: rdy=%0b sz=%0h want 1 0", req_rdy, lsu_fwd_inst_size);
    end
  endtask

  task automatic test_same_cycle();
    start_req(3, 24, 2, 3);
    tick();
    drive(1, 1);
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b0 || lsu_fwd_rot !== 4'h8) begin
      bad++;
      $display("FAIL same_b2: vld=%0b last=%0b rot=%0h want 1 0 8", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'h0) begin
      bad++;
      $display("FAIL same_b3: vld=%0b last=%0b rot=%0h want 1 1 0", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
    total++;
    if (vlsu_fwd_vld !== 1'b0 || req_rdy !== 1'b0 || lsu_fwd_rot !== 4'h8) begin
      bad++;
      $display("FAIL same_drain: vld=%0b rdy=%0b rot=%0h want 0 0 8", vlsu_fwd_vld, req_rdy, lsu_fwd_rot);
    end
    // extra fwd_next with no sources left must not wrap the counter
    drive(1, 0);
    total++;
    if (vlsu_fwd_vld !== 1'b0 || vlsu_reg_seq_last !== 1'b0 || req_rdy !== 1'b0) begin
      bad++;
      $display("FAIL same_underflow: vld=%0b last=%0b rdy=%0b want 0 0 0", vlsu_fwd_vld, vlsu_reg_seq_last, req_rdy);
    end
    drive(0, 1);
    total++;
    if (req_rdy !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL same_end: rdy=%0b pending=%0d want 1 0", req_rdy, exp_q.size());
    end
  endtask

  task automatic test_ignore_done();
    mon_en = 1'b0;
    lsu_fwd_done = 1'b1;
    #2;
    total++;
    if (st_done !== 1'b0 || req_rdy !== 1'b1) begin
      bad++;
      $display("FAIL ign_idle: st_done=%0b rdy=%0b want 0 1", st_done, req_rdy);
    end
    tick();
    lsu_fwd_done = 1'b0;
    start_req(0, 8, 2, 2);
    lsu_fwd_done = 1'b1;
    #2;
    total++;
    if (st_done !== 1'b0 || vlsu_warm_up !== 1'b1) begin
      bad++;
      $display("FAIL ign_warm: st_done=%0b warm=%0b want 0 1", st_done, vlsu_warm_up);
    end
    tick();
    lsu_fwd_done = 1'b0;
    mon_en = 1'b1;
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'h0) begin
      bad++;
      $display("FAIL ign_fwd: vld=%0b last=%0b rot=%0h want 1 1 0", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
  endtask

  task automatic test_flush();
    start_req(0, 16, 3, 1);
    tick();
    drive(1, 0);
    total++;
    if (vlsu_reg_seq_last !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre: last=%0b want 1", vlsu_reg_seq_last);
    end
    rtu_yy_xx_flush = 1'b1;
    #2;
    total++;
    if (st_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle: st_done=%0b want 0", st_done);
    end
    tick();
    rtu_yy_xx_flush = 1'b0;
    exp_q.delete();
    total++;
    if ({req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
         lsu_fwd_inst_size, lsu_fwd_sew, st_done} !== {1'b1, 3'b000, 4'h0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL flush_after: rdy=%0b vld=%0b last=%0b warm=%0b rot=%0h sz=%0h sew=%0h done=%0b want rdy=1 rest 0",
               req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
               lsu_fwd_inst_size, lsu_fwd_sew, st_done);
    end
    start_req(8, 4, 1, 2);
    tick();
    total++;
    if (vlsu_fwd_vld !== 1'b1 || vlsu_reg_seq_last !== 1'b1 || lsu_fwd_rot !== 4'h8) begin
      bad++;
      $display("FAIL flush_new: vld=%0b last=%0b rot=%0h want 1 1 8", vlsu_fwd_vld, vlsu_reg_seq_last, lsu_fwd_rot);
    end
    drive(1, 1);
  endtask

  task automatic test_reset_drain();
    start_req(5, 16, 2, 3);
    tick();
    drive(1, 0);
    drive(1, 0);
    drive(0, 1);
    total++;
    if (vlsu_fwd_vld !== 1'b0 || req_rdy !== 1'b0 || lsu_fwd_rot !== 4'h8) begin
      bad++;
      $display("FAIL rst_drain_pre: vld=%0b rdy=%0b rot=%0h want 0 0 8", vlsu_fwd_vld, req_rdy, lsu_fwd_rot);
    end
    #2;
    cpurst_b = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if ({req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
         lsu_fwd_inst_size, lsu_fwd_sew, st_done} !== {1'b1, 3'b000, 4'h0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL rst_drain_async: rdy=%0b vld=%0b last=%0b warm=%0b rot=%0h sz=%0h sew=%0h done=%0b want rdy=1 rest 0",
               req_rdy, vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_warm_up, lsu_fwd_rot,
               lsu_fwd_inst_size, lsu_fwd_sew, st_done);
    end
    @(negedge align_clk);
    cpurst_b = 1'b1;
    tick();
  endtask

  initial begin
    cpurst_b        = 1'b0;
    rtu_yy_xx_flush = 1'b0;
    req_vld         = 1'b0;
    req_addr        = '0;
    req_len         = '0;
    req_inst_size   = '0;
    req_sew         = '0;
    fwd_next        = 1'b0;
    lsu_fwd_done    = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_aligned();
    test_misaligned();
    test_short();
    test_same_cycle();
    test_ignore_done();
    test_flush();
    test_reset_drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
